// File: rtl/mult32.sv
// rtl/mult32.sv - 32x32 unsigned multiplier built from four 16x16 partial products
module mult32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [63:0] result,
    output logic        done
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] acc;

    logic [15:0] half_a;
    logic [15:0] half_b;
    logic [5:0]  shift;
    logic [31:0] pp32;
    logic [63:0] pp64;

    // Step order: lo*lo, hi*lo, lo*hi, hi*hi
    always_comb begin
        half_a = a_reg[15:0];
        half_b = b_reg[15:0];
        shift  = 6'd0;
        case (step)
            2'd0: begin
                half_a = a_reg[15:0];
                half_b = b_reg[15:0];
                shift  = 6'd0;
            end
            2'd1: begin
                half_a = a_reg[31:16];
                half_b = b_reg[15:0];
                shift  = 6'd16;
            end
            2'd2: begin
                half_a = a_reg[15:0];
                half_b = b_reg[31:16];
                shift  = 6'd16;
            end
            default: begin
                half_a = a_reg[31:16];
                half_b = b_reg[31:16];
                shift  = 6'd32;
            end
        endcase
        pp32 = {16'd0, half_a} * {16'd0, half_b};
        pp64 = {32'd0, pp32} << shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_LOAD;
            step   <= 2'd0;
            a_reg  <= 32'd0;
            b_reg  <= 32'd0;
            acc    <= 64'd0;
            result <= 64'd0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    a_reg <= dataa;
                    b_reg <= datab;
                    acc   <= 64'd0;
                    step  <= 2'd0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    acc  <= acc + pp64;
                    step <= step + 2'd1;
                    // result is only written once, with the complete sum
                    if (step == 2'd3) begin
                        result <= acc + pp64;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult32.sv
// tb/tb_mult32.sv - self-checking bench for mult32 against an arithmetic product model
module tb_mult32;

    logic        clk;
    logic        reset;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [63:0] result;
    logic        done;

    int n_checks;
    int n_fail;

    mult32 dut (
        .clk    (clk),
        .reset  (reset),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One reset edge, then release; expects done exactly on the 5th edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input logic [31:0] a2, input logic [31:0] b2);
        logic [63:0] exp;
        exp   = model(a, b);
        reset = 1'b1;
        dataa = a;
        datab = b;
        tick();
        check({tag, " rst result"}, result, 64'd0);
        check({tag, " rst done"}, {63'd0, done}, 64'd0);
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (scramble) begin
                dataa = (e == 1) ? a2 : $urandom;
                datab = (e == 1) ? b2 : $urandom;
            end
            if (e < 5) begin
                check($sformatf("%s e%0d done", tag, e), {63'd0, done}, 64'd0);
                check($sformatf("%s e%0d result", tag, e), result, 64'd0);
            end else begin
                check({tag, " done"}, {63'd0, done}, 64'd1);
                check({tag, " result"}, result, exp);
            end
        end
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        dataa    = 32'd0;
        datab    = 32'd0;

        // Multi-cycle reset holds outputs at zero
        for (int i = 0; i < 3; i++) begin
            dataa = $urandom;
            datab = $urandom;
            tick();
            check("hold rst result", result, 64'd0);
            check("hold rst done", {63'd0, done}, 64'd0);
        end

        run_op("r25", 32'd1507328, 32'd4325, 1'b0, 32'd0, 32'd0);
        check("r25 const", result, 64'd6519193600);
        run_op("r26", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
        check("r26 const", result, 64'hFFFF_FFFE_0000_0001);
        run_op("r27a", 32'd0, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
        run_op("r27b", 32'd1, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
        check("r27b const", result, 64'h0000_0000_DEAD_BEEF);
        run_op("r28", 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd7, 32'd9);
        check("r28 const", result, 64'h1_0000_0000);

        // After done, inputs wander and nothing moves
        held = result;
        for (int i = 0; i < 10; i++) begin
            dataa = $urandom;
            datab = $urandom;
            tick();
            check("r30 result", result, held);
            check("r30 done", {63'd0, done}, 64'd1);
        end

        // Reset in DONE clears outputs on that edge
        reset = 1'b1;
        tick();
        check("rst in done result", result, 64'd0);
        check("rst in done done", {63'd0, done}, 64'd0);

        // Abort mid-operation: reset sampled at edge 3 after release
        reset = 1'b0;
        dataa = 32'hABCD_1234;
        datab = 32'h5678_9ABC;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("r29 abort done", {63'd0, done}, 64'd0);
        check("r29 abort result", result, 64'd0);
        run_op("r29", 32'd3, 32'd5, 1'b0, 32'd0, 32'd0);
        check("r29 const", result, 64'd15);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) ra[15:0] = 16'hFFFF;
            if (i % 4 == 1) rb[31:16] = 16'hFFFF;
            run_op($sformatf("rnd%0d", i), ra, rb, (i % 2) == 1, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult32.md
MULT32 -- requirements
Module: mult32

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32 bits, product width at 64 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high; it also starts a new multiplication when released.
REQ-004 SHALL have port dataa, input, 32 bits: unsigned multiplicand.
REQ-005 SHALL have port datab, input, 32 bits: unsigned multiplier.
REQ-006 SHALL have port result, output, 64 bits: unsigned product dataa*datab, registered.
REQ-007 SHALL have port done, output, 1 bit: high when result holds the final product.

Function
REQ-008 SHALL compute the full unsigned 64-bit product; no truncation, no overflow possible, no signed interpretation.
REQ-009 SHALL have no start/valid input: each operation begins on the first rising edge with reset low after reset was high.
REQ-010 SHALL use a state machine with states LOAD, MUL (4 steps, 2-bit step counter 0..3) and DONE.
REQ-011 LOAD, 1st edge after reset release: SHALL capture dataa/datab into internal operand registers, clear the accumulator, step counter to 0, and go to MUL.
REQ-012 MUL: SHALL form one 16x16 unsigned partial product per edge from captured operand halves: step0 a[15:0]*b[15:0] shifted 0; step1 a[31:16]*b[15:0] shifted 16; step2 a[15:0]*b[31:16] shifted 16; step3 a[31:16]*b[31:16] shifted 32.
REQ-013 MUL: SHALL add each shifted partial product into a 64-bit accumulator; additions modulo 2^64, never actually overflowing.
REQ-014 On the step3 edge, the 5th edge after reset release, SHALL load the final sum into result, set done to 1 and go to DONE.
REQ-015 DONE: SHALL hold result and done=1 unchanged until the next reset; no automatic restart.
REQ-016 Latency SHALL be exactly 5 rising edges from reset release to done=1; 6 edges is the maximum permitted by verification.
REQ-017 dataa/datab changes after the LOAD edge SHALL NOT affect the current operation's result.
REQ-018 result SHALL stay 0 while done=0; intermediate sums SHALL NOT appear on result.
REQ-019 done SHALL rise exactly once per operation and SHALL never glitch; it is a register output.
REQ-020 SHALL be fully synchronous, with no combinational path from any input to any output.

Reset
REQ-021 While reset=1 at a rising edge: result SHALL be 0, done 0, accumulator 0, operand registers 0, state LOAD, step counter 0.
REQ-022 Reset asserted mid-operation, in MUL or DONE, SHALL abort the operation; the same reset values apply on that edge.
REQ-023 Release after a mid-operation reset SHALL start a fresh operation on current inputs, with full 5-edge latency.
REQ-024 Reset held for multiple cycles SHALL keep all outputs at reset values; the operation starts only after release.

Verification
REQ-025 dataa=1507328, datab=4325; reset 1 cycle, 20 ns period -> done=1 and result=6519193600 at or before the 6th edge after release.
REQ-026 dataa=0xFFFFFFFF, datab=0xFFFFFFFF -> result=0xFFFFFFFE00000001, done=1 after 5 edges; done=0 and result=0 on edges 1-4.
REQ-027 dataa=0, datab=0x12345678 -> result=0, done=1 after 5 edges; dataa=1, datab=0xDEADBEEF -> result=0x00000000DEADBEEF.
REQ-028 dataa=0x10000, datab=0x10000; change inputs to 7 and 9 after the LOAD edge -> result=0x100000000, not 63.
REQ-029 Assert reset at edge 3 of an operation, then release with dataa=3, datab=5 -> done=0 at that edge, then done=1 and result=15 exactly 5 edges after release.
REQ-030 After done=1, hold 10 further cycles with changing inputs -> result and done unchanged.
